// File: rtl/pipe_hzd_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage pipeline.
// Sits beside ID and drives every pipeline-register enable, ID/EX bubble and flush.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   src_reg, src_en     ID source indices (operand k at [k*REG_AW +: REG_AW]) and read flags
//   hlt_id, hlt_wb      HLT decoded in ID / HLT resident in MEM/WB
//   ex_*, mem_*, wb_*   destination index, write enable and load flag per stage
//   redirect            taken branch/jump resolved in MEM
//   i_rdy, d_rdy        cache ready; either low freezes the whole pipe
//   fwd_sel             per operand: 00 none, 01 EX, 10 MEM, 11 WB
//   *_en, bubble, flush pipeline-register control
//   halted              processor halted (registered)
//   stall_cnt/flush_cnt saturating event counters
module pipe_hzd_ctrl #(
    parameter int NSRC     = 2,
    parameter int REG_AW   = 4,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NSRC*REG_AW-1:0]   src_reg,
    input  logic [NSRC-1:0]          src_en,
    input  logic                     hlt_id,
    input  logic [REG_AW-1:0]        ex_wr_reg,
    input  logic [REG_AW-1:0]        mem_wr_reg,
    input  logic [REG_AW-1:0]        wb_wr_reg,
    input  logic                     ex_wr_en,
    input  logic                     mem_wr_en,
    input  logic                     wb_wr_en,
    input  logic                     ex_is_ld,
    input  logic                     mem_is_ld,
    input  logic                     hlt_wb,
    input  logic                     redirect,
    input  logic                     i_rdy,
    input  logic                     d_rdy,
    output logic [2*NSRC-1:0]        fwd_sel,
    output logic                     pc_en,
    output logic                     if_id_en,
    output logic                     id_ex_en,
    output logic                     ex_mem_en,
    output logic                     mem_wb_en,
    output logic                     bubble,
    output logic                     flush,
    output logic                     halted,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t state, nxt;

    logic [2*NSRC-1:0] fwd_raw;
    logic [NSRC-1:0]   haz_vec;
    logic              ld_haz;
    logic              freeze;
    logic              stall_inc;
    logic              flush_inc;

    // Per-operand producer search; the youngest matching stage wins, so an
    // older load shadowed by a younger non-load writer never stalls.
    genvar k;
    for (k = 0; k < NSRC; k++) begin : g_op
        logic [REG_AW-1:0] idx;
        logic [1:0]        sel;
        logic              hz;

        assign idx = src_reg[k*REG_AW +: REG_AW];

        always_comb begin
            sel = 2'b00;
            hz  = 1'b0;
            if (src_en[k] && idx != '0) begin
                if (ex_wr_en && ex_wr_reg == idx) begin
                    sel = 2'b01;
                    hz  = ex_is_ld;
                end else if (mem_wr_en && mem_wr_reg == idx) begin
                    sel = 2'b10;
                    hz  = (LOAD_LAT == 2) && mem_is_ld;
                end else if (wb_wr_en && wb_wr_reg == idx) begin
                    sel = 2'b11;
                end
            end
        end

        assign fwd_raw[2*k +: 2] = sel;
        assign haz_vec[k]        = hz;
    end

    assign ld_haz  = |haz_vec;
    assign freeze  = ~i_rdy | ~d_rdy;
    assign fwd_sel = rst ? '0 : fwd_raw;
    assign halted  = (state == S_HALTED);

    always_comb begin
        nxt       = state;
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        if (rst || freeze || state == S_HALTED) begin
            // everything held; defaults already zero
        end else if (redirect) begin
            // a redirect also cancels a drain: the HLT was on the wrong path
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
            flush     = 1'b1;
            flush_inc = 1'b1;
            nxt       = S_RUN;
        end else if (ld_haz) begin
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            bubble    = 1'b1;
            stall_inc = 1'b1;
        end else if (state == S_DRAIN) begin
            // HLT stays parked in IF/ID; older work drains behind bubbles
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            bubble    = 1'b1;
            if (hlt_wb) begin
                nxt = S_HALTED;
            end
        end else if (hlt_id) begin
            // let the HLT itself advance into EX, stop fetching behind it
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            nxt       = S_DRAIN;
        end else begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= nxt;
            if (stall_inc && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && flush_cnt != {CNT_W{1'b1}}) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hzd_ctrl.sv
// Directed bench for pipe_hzd_ctrl: LOAD_LAT=1, LOAD_LAT=2 and a
// narrow-counter instance share one stimulus stream.
module tb_pipe_hzd_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  src_reg;
    logic [1:0]  src_en;
    logic        hlt_id;
    logic [3:0]  ex_wr_reg, mem_wr_reg, wb_wr_reg;
    logic        ex_wr_en, mem_wr_en, wb_wr_en;
    logic        ex_is_ld, mem_is_ld;
    logic        hlt_wb, redirect, i_rdy, d_rdy;

    logic [3:0]  fwd1, fwd2, fwds;
    logic [4:0]  en1, en2, ens;
    logic        bub1, bub2, bubs;
    logic        fl1, fl2, fls;
    logic        hl1, hl2, hls;
    logic [15:0] sc1, sc2, fc1, fc2;
    logic [1:0]  scs, fcs;

    int n_vec = 0;
    int n_err = 0;

    pipe_hzd_ctrl #(.LOAD_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .src_reg(src_reg), .src_en(src_en),
        .hlt_id(hlt_id), .ex_wr_reg(ex_wr_reg), .mem_wr_reg(mem_wr_reg),
        .wb_wr_reg(wb_wr_reg), .ex_wr_en(ex_wr_en), .mem_wr_en(mem_wr_en),
        .wb_wr_en(wb_wr_en), .ex_is_ld(ex_is_ld), .mem_is_ld(mem_is_ld),
        .hlt_wb(hlt_wb), .redirect(redirect), .i_rdy(i_rdy), .d_rdy(d_rdy),
        .fwd_sel(fwd1), .pc_en(en1[4]), .if_id_en(en1[3]), .id_ex_en(en1[2]),
        .ex_mem_en(en1[1]), .mem_wb_en(en1[0]), .bubble(bub1), .flush(fl1),
        .halted(hl1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    pipe_hzd_ctrl #(.LOAD_LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .src_reg(src_reg), .src_en(src_en),
        .hlt_id(hlt_id), .ex_wr_reg(ex_wr_reg), .mem_wr_reg(mem_wr_reg),
        .wb_wr_reg(wb_wr_reg), .ex_wr_en(ex_wr_en), .mem_wr_en(mem_wr_en),
        .wb_wr_en(wb_wr_en), .ex_is_ld(ex_is_ld), .mem_is_ld(mem_is_ld),
        .hlt_wb(hlt_wb), .redirect(redirect), .i_rdy(i_rdy), .d_rdy(d_rdy),
        .fwd_sel(fwd2), .pc_en(en2[4]), .if_id_en(en2[3]), .id_ex_en(en2[2]),
        .ex_mem_en(en2[1]), .mem_wb_en(en2[0]), .bubble(bub2), .flush(fl2),
        .halted(hl2), .stall_cnt(sc2), .flush_cnt(fc2)
    );

    pipe_hzd_ctrl #(.LOAD_LAT(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .src_reg(src_reg), .src_en(src_en),
        .hlt_id(hlt_id), .ex_wr_reg(ex_wr_reg), .mem_wr_reg(mem_wr_reg),
        .wb_wr_reg(wb_wr_reg), .ex_wr_en(ex_wr_en), .mem_wr_en(mem_wr_en),
        .wb_wr_en(wb_wr_en), .ex_is_ld(ex_is_ld), .mem_is_ld(mem_is_ld),
        .hlt_wb(hlt_wb), .redirect(redirect), .i_rdy(i_rdy), .d_rdy(d_rdy),
        .fwd_sel(fwds), .pc_en(ens[4]), .if_id_en(ens[3]), .id_ex_en(ens[2]),
        .ex_mem_en(ens[1]), .mem_wb_en(ens[0]), .bubble(bubs), .flush(fls),
        .halted(hls), .stall_cnt(scs), .flush_cnt(fcs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        src_reg    = '0;
        src_en     = '0;
        hlt_id     = 1'b0;
        ex_wr_reg  = '0;
        mem_wr_reg = '0;
        wb_wr_reg  = '0;
        ex_wr_en   = 1'b0;
        mem_wr_en  = 1'b0;
        wb_wr_en   = 1'b0;
        ex_is_ld   = 1'b0;
        mem_is_ld  = 1'b0;
        hlt_wb     = 1'b0;
        redirect   = 1'b0;
        i_rdy      = 1'b1;
        d_rdy      = 1'b1;
    endtask

    // drive just after the edge, sample mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // LW r5 in EX, ID reads r5 on operand 0
    task automatic lw_ex_r5();
        idle();
        src_reg   = 8'h05;
        src_en    = 2'b01;
        ex_wr_reg = 4'd5;
        ex_wr_en  = 1'b1;
        ex_is_ld  = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        src_reg   = 8'h03;
        src_en    = 2'b01;
        ex_wr_reg = 4'd3;
        ex_wr_en  = 1'b1;
        #4;
        chk("rst_en", en1, 5'b00000);
        chk("rst_fwd", fwd1, 4'b0000);
        chk("rst_bub", bub1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        idle();
        settle();
        chk("rst_sc", sc1, 0);
        chk("rst_fc", fc1, 0);
        chk("rst_halt", hl1, 0);
        chk("idle_en", en1, 5'b11111);

        // ADD r3 in EX, ID reads r3
        tick();
        src_reg   = 8'h03;
        src_en    = 2'b01;
        ex_wr_reg = 4'd3;
        ex_wr_en  = 1'b1;
        settle();
        chk("add_fwd", fwd1, 4'b0001);
        chk("add_en", en1, 5'b11111);
        chk("add_bub", bub1, 0);

        // priority and per-operand select
        tick();
        src_reg    = 8'h73;
        src_en     = 2'b11;
        mem_wr_reg = 4'd3;
        mem_wr_en  = 1'b1;
        wb_wr_reg  = 4'd7;
        wb_wr_en   = 1'b1;
        settle();
        chk("pri_ex", fwd1, 4'b1101);
        tick();
        ex_wr_en = 1'b0;
        settle();
        chk("pri_mem", fwd1, 4'b1110);
        tick();
        src_en = 2'b10;
        settle();
        chk("src_dis", fwd1, 4'b1100);

        // r0 never forwarded, never stalls
        tick();
        idle();
        src_en    = 2'b11;
        ex_wr_en  = 1'b1;
        ex_is_ld  = 1'b1;
        mem_wr_en = 1'b1;
        wb_wr_en  = 1'b1;
        settle();
        chk("r0_fwd", fwd1, 4'b0000);
        chk("r0_en", en1, 5'b11111);

        // load-use
        tick();
        lw_ex_r5();
        settle();
        chk("lu1_bub", bub1, 1);
        chk("lu1_en", en1, 5'b00111);
        chk("lu2_bub", bub2, 1);
        tick();
        idle();
        src_reg    = 8'h05;
        src_en     = 2'b01;
        mem_wr_reg = 4'd5;
        mem_wr_en  = 1'b1;
        mem_is_ld  = 1'b1;
        settle();
        chk("lu1_fwd", fwd1, 4'b0010);
        chk("lu1_nobub", bub1, 0);
        chk("lu1_en2", en1, 5'b11111);
        chk("lu2_bub2", bub2, 1);
        chk("lu2_en2", en2, 5'b00111);
        tick();
        idle();
        src_reg   = 8'h05;
        src_en    = 2'b01;
        wb_wr_reg = 4'd5;
        wb_wr_en  = 1'b1;
        settle();
        chk("lu2_fwd", fwd2, 4'b0011);
        chk("lu2_en3", en2, 5'b11111);
        chk("lu1_sc", sc1, 1);
        chk("lu2_sc", sc2, 2);

        // younger ALU write masks the older load
        tick();
        idle();
        src_reg    = 8'h05;
        src_en     = 2'b01;
        ex_wr_reg  = 4'd5;
        ex_wr_en   = 1'b1;
        mem_wr_reg = 4'd5;
        mem_wr_en  = 1'b1;
        mem_is_ld  = 1'b1;
        settle();
        chk("mask_fwd", fwd2, 4'b0001);
        chk("mask_bub", bub2, 0);
        chk("mask_en", en2, 5'b11111);

        // D-cache miss during load-use
        for (int i = 0; i < 3; i++) begin
            tick();
            lw_ex_r5();
            d_rdy = 1'b0;
            settle();
            chk("frz_en", en1, 5'b00000);
            chk("frz_bub", bub1, 0);
        end
        tick();
        lw_ex_r5();
        settle();
        chk("frz_sc", sc1, 1);
        chk("post_bub", bub1, 1);
        tick();
        idle();
        settle();
        chk("post_sc", sc1, 2);

        // redirect together with load-use: flush only
        tick();
        lw_ex_r5();
        redirect = 1'b1;
        settle();
        chk("rd_flush", fl1, 1);
        chk("rd_en", en1, 5'b11111);
        chk("rd_bub", bub1, 0);
        tick();
        idle();
        settle();
        chk("rd_fc", fc1, 1);
        chk("rd_sc", sc1, 2);

        // halt cancelled by an older redirect
        tick();
        hlt_id = 1'b1;
        settle();
        chk("h_en", en1, 5'b00111);
        chk("h_bub", bub1, 0);
        tick();
        settle();
        chk("dr_bub", bub1, 1);
        chk("dr_en", en1, 5'b00111);
        tick();
        hlt_id   = 1'b0;
        redirect = 1'b1;
        settle();
        chk("dr_flush", fl1, 1);
        chk("dr_en2", en1, 5'b11111);
        tick();
        idle();
        settle();
        chk("back_en", en1, 5'b11111);
        chk("back_bub", bub1, 0);
        chk("back_fc", fc1, 2);

        // halt reaching WB
        tick();
        hlt_id = 1'b1;
        tick();
        settle();
        chk("h2_bub", bub1, 1);
        tick();
        hlt_wb = 1'b1;
        settle();
        chk("h2_halt0", hl1, 0);
        tick();
        idle();
        redirect = 1'b1;
        settle();
        chk("halted", hl1, 1);
        chk("hlt_en", en1, 5'b00000);
        chk("hlt_fl", fl1, 0);
        tick();
        idle();
        settle();
        chk("hlt_fc", fc1, 2);
        chk("hlt_stay", hl1, 1);

        // reset out of halt
        rst = 1'b1;
        settle();
        chk("rst2_en", en1, 5'b00000);
        tick();
        rst = 1'b0;
        settle();
        chk("rst2_halt", hl1, 0);
        chk("rst2_sc", sc1, 0);
        chk("rst2_fc", fc1, 0);
        chk("rst2_en2", en1, 5'b11111);

        // reset mid-drain leaves no residual bubble
        tick();
        hlt_id = 1'b1;
        tick();
        hlt_id = 1'b0;
        settle();
        chk("rd_drain", bub1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("rdn_bub", bub1, 0);
        chk("rdn_en", en1, 5'b11111);

        // counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            tick();
            lw_ex_r5();
        end
        tick();
        idle();
        settle();
        chk("sat_sc", scs, 2'd3);
        chk("wide_sc", sc1, 5);
        for (int i = 0; i < 4; i++) begin
            tick();
            idle();
            redirect = 1'b1;
        end
        tick();
        idle();
        settle();
        chk("sat_fc", fcs, 2'd3);
        chk("wide_fc", fc1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
